// File: rtl/flex_updown_counter.sv
// Programmable up/down counter over the range [1 .. rollover_val] with wrap or
// saturate behaviour, parallel load, and registered rollover/zero/wrap flags.
module flex_updown_counter #(
  parameter int NUM_BITS = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clear,
  input  logic                load,
  input  logic [NUM_BITS-1:0] load_val,
  input  logic                count_enable,
  input  logic                count_down,
  input  logic                saturate,
  input  logic [NUM_BITS-1:0] rollover_val,
  output logic [NUM_BITS-1:0] count_out,
  output logic                rollover_flag,
  output logic                zero_flag,
  output logic                wrap_pulse
);

  localparam logic [NUM_BITS-1:0] ZERO_VAL = {NUM_BITS{1'b0}};
  localparam logic [NUM_BITS-1:0] ONE_VAL  = {{(NUM_BITS-1){1'b0}}, 1'b1};

  logic [NUM_BITS-1:0] count_r;
  logic                rollover_flag_r;
  logic                zero_flag_r;
  logic                wrap_pulse_r;

  logic [NUM_BITS-1:0] next_count_s;
  logic                wrap_s;

  // Next-count selection: clear > load > step > hold.
  always_comb begin
    next_count_s = count_r;
    wrap_s       = 1'b0;
    if (clear) begin
      next_count_s = ZERO_VAL;
    end else if (load) begin
      next_count_s = load_val;
    end else if (count_enable && (rollover_val != ZERO_VAL)) begin
      if (!count_down) begin
        // Values above rollover_val (e.g. after an unchecked load) also wrap.
        if (count_r < rollover_val) begin
          next_count_s = count_r + ONE_VAL;
        end else if (!saturate) begin
          next_count_s = ONE_VAL;
          wrap_s       = 1'b1;
        end else begin
          next_count_s = count_r;
        end
      end else begin
        if (count_r > ONE_VAL) begin
          next_count_s = count_r - ONE_VAL;
        end else if (!saturate) begin
          next_count_s = rollover_val;
          wrap_s       = 1'b1;
        end else begin
          next_count_s = count_r;
        end
      end
    end else begin
      next_count_s = count_r;
    end
  end

  // Count and flag registers; flags are derived from the next count so they
  // line up with count_out.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_r         <= ZERO_VAL;
      rollover_flag_r <= 1'b0;
      zero_flag_r     <= 1'b0;
      wrap_pulse_r    <= 1'b0;
    end else begin
      count_r         <= next_count_s;
      rollover_flag_r <= (next_count_s == rollover_val);
      zero_flag_r     <= (next_count_s == ZERO_VAL);
      wrap_pulse_r    <= wrap_s;
    end
  end

  assign count_out     = count_r;
  assign rollover_flag = rollover_flag_r;
  assign zero_flag     = zero_flag_r;
  assign wrap_pulse    = wrap_pulse_r;

endmodule

// File: tb/tb_flex_updown_counter.sv
// Scoreboard bench for flex_updown_counter: directed scenarios followed by
// randomized traffic, checked against an integer reference model.
module tb_flex_updown_counter;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         clear = 1'b0;
  logic         load = 1'b0;
  logic [W-1:0] load_val = 4'd0;
  logic         count_enable = 1'b0;
  logic         count_down = 1'b0;
  logic         saturate = 1'b0;
  logic [W-1:0] rollover_val = 4'd0;
  logic [W-1:0] count_out;
  logic         rollover_flag;
  logic         zero_flag;
  logic         wrap_pulse;

  typedef struct packed {
    logic [W-1:0] cnt;
    logic         rf;
    logic         zf;
    logic         wp;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   m_count = 0;

  flex_updown_counter #(.NUM_BITS(W)) dut (
    .clk(clk), .rst(rst), .clear(clear), .load(load), .load_val(load_val),
    .count_enable(count_enable), .count_down(count_down), .saturate(saturate),
    .rollover_val(rollover_val), .count_out(count_out),
    .rollover_flag(rollover_flag), .zero_flag(zero_flag), .wrap_pulse(wrap_pulse)
  );

  always #5 clk = ~clk;

  // Drive one edge worth of inputs and push the model's expected result.
  task automatic step(input logic r, input logic c, input logic l, input int lv,
                      input logic en, input logic dn, input logic sat, input int rv);
    exp_t e;
    logic wrapped;
    @(negedge clk);
    rst = r; clear = c; load = l; load_val = lv[W-1:0];
    count_enable = en; count_down = dn; saturate = sat; rollover_val = rv[W-1:0];
    wrapped = 1'b0;
    if (r) begin
      m_count = 0;
      e = '{cnt: 4'd0, rf: 1'b0, zf: 1'b0, wp: 1'b0};
    end else begin
      if (c) m_count = 0;
      else if (l) m_count = lv;
      else if (en && rv != 0) begin
        if (!dn) begin
          if (m_count < rv) m_count = m_count + 1;
          else if (!sat) begin m_count = 1; wrapped = 1'b1; end
        end else begin
          if (m_count > 1) m_count = m_count - 1;
          else if (!sat) begin m_count = rv; wrapped = 1'b1; end
        end
      end
      e.cnt = m_count[W-1:0];
      e.rf  = (m_count == rv);
      e.zf  = (m_count == 0);
      e.wp  = wrapped;
    end
    sb.push_back(e);
  endtask

  // Monitor: one expected entry per edge, compared just after the edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        checks++;
        if (count_out !== e.cnt) begin
          errors++;
          $display("FAIL count_out t=%0t got %0d exp %0d", $time, count_out, e.cnt);
        end
        checks++;
        if (rollover_flag !== e.rf) begin
          errors++;
          $display("FAIL rollover_flag t=%0t got %b exp %b", $time, rollover_flag, e.rf);
        end
        checks++;
        if (zero_flag !== e.zf) begin
          errors++;
          $display("FAIL zero_flag t=%0t got %b exp %b", $time, zero_flag, e.zf);
        end
        checks++;
        if (wrap_pulse !== e.wp) begin
          errors++;
          $display("FAIL wrap_pulse t=%0t got %b exp %b", $time, wrap_pulse, e.wp);
        end
      end
    end
  end

  initial begin
    // Up wrap from reset: 1,2,3,1,2,3
    step(1, 0, 0, 0, 0, 0, 0, 3);
    for (int i = 0; i < 6; i++) step(0, 0, 0, 0, 1, 0, 0, 3);

    // Reset mid-count at 5, then idle with enable low
    step(0, 0, 1, 5, 0, 0, 0, 7);
    step(0, 0, 0, 0, 0, 0, 0, 7);
    step(1, 0, 0, 0, 1, 0, 0, 7);
    step(1, 0, 0, 0, 1, 0, 0, 7);
    step(0, 0, 0, 0, 0, 0, 0, 7);

    // Up saturate at 5
    for (int i = 0; i < 8; i++) step(0, 0, 0, 0, 1, 0, 1, 5);

    // Down wrap from 2 with rollover 6, then saturate at the bottom
    step(0, 0, 1, 2, 0, 1, 0, 6);
    for (int i = 0; i < 6; i++) step(0, 0, 0, 0, 1, 1, 0, 6);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 1, 1, 1, 6);

    // Priority and out-of-range load
    step(0, 1, 1, 9, 1, 0, 0, 5);
    step(0, 0, 1, 9, 0, 0, 0, 5);
    step(0, 0, 0, 0, 1, 0, 0, 5);
    step(0, 0, 1, 4, 1, 0, 0, 5);
    // Down from above the range still decrements
    step(0, 0, 1, 12, 0, 0, 0, 5);
    step(0, 0, 0, 0, 1, 1, 0, 5);

    // rollover_val of zero freezes stepping
    step(0, 0, 1, 7, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 1, 0, 0, 0);
    step(0, 0, 1, 2, 1, 0, 0, 0);

    // Consecutive wraps with rollover_val 1, and the all-ones boundary
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 1, 0, 0, 1);
    step(0, 0, 1, 14, 0, 0, 0, 15);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 1, 0, 0, 15);
    step(0, 0, 1, 1, 0, 0, 0, 15);
    for (int i = 0; i < 2; i++) step(0, 0, 0, 0, 1, 1, 0, 15);

    // Randomized traffic
    for (int i = 0; i < 500; i++) begin
      step(($urandom_range(0, 99) < 2),
           ($urandom_range(0, 99) < 4),
           ($urandom_range(0, 99) < 10),
           int'($urandom_range(0, 15)),
           ($urandom_range(0, 99) < 80),
           ($urandom_range(0, 1) == 1),
           ($urandom_range(0, 99) < 30),
           (($urandom_range(0, 99) < 5) ? 0 : int'($urandom_range(1, 15))));
    end

    // Let the last edge drain through the monitor
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain got %0d pending exp 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/flex_updown_counter.md
# flex_updown_counter

Parametrised successor to the team's flex counter. Same rollover-style counting, generalised to any width, with additions:
- up/down direction;
- parallel load;
- per-cycle wrap or saturate mode;
- registered wrap pulse.

It serves as the general-purpose programmable counter for timers, baud/bit counters and FIFO pointer helpers. All state and outputs are registered on one clock.

## Interface
- NUM_BITS, default 4: width of the count, load value and rollover value (≥ 2).

- clk  in  1  rising-edge clock.
- rst  in  1  reset, synchronous, active-high.
- clear  in  1  synchronous clear of the count.
- load  in  1  synchronous parallel load of load_val.
- load_val  in  NUM_BITS  value captured on load.
- count_enable  in  1  advance the count by one step this cycle.
- count_down  in  1  0 = count up, 1 = count down; sampled each cycle.
- saturate  in  1  0 = wrap at terminal value, 1 = hold at terminal value; sampled each cycle.
- rollover_val  in  NUM_BITS  upper bound of the count range [1 .. rollover_val].
- count_out  out  NUM_BITS  current count, registered.
- rollover_flag  out  1  registered; high when count_out == rollover_val.
- zero_flag  out  1  registered; high when count_out == 0.
- wrap_pulse  out  1  registered; one-cycle pulse on the cycle after a wrap.

## Operation
- Control priority, evaluated at each rising edge: rst > clear > load > count_enable > hold.
- rst: count_out=0, rollover_flag=0, zero_flag=0, wrap_pulse=0. Note zero_flag is 0 in reset even though count is 0; it asserts 1 on the first edge after rst deasserts.
- clear: next count = 0; wrap_pulse=0.
- load: next count = load_val, no range check; wrap_pulse=0.
- rollover_val == 0: count_enable is ignored and the count holds. clear and load still act.
- Up count (count_down=0, count_enable=1, rollover_val≠0):
  - count_out < rollover_val: next = count_out+1.
  - count_out ≥ rollover_val, saturate=0: next = 1 and a wrap is recorded.
  - count_out ≥ rollover_val, saturate=1: next = count_out (hold).
- Down count (count_down=1, count_enable=1, rollover_val≠0):
  - count_out > 1: next = count_out−1. This applies even when count_out > rollover_val.
  - count_out ≤ 1, saturate=0: next = rollover_val and a wrap is recorded.
  - count_out ≤ 1, saturate=1: hold.
- Arithmetic is NUM_BITS unsigned. No natural binary overflow is ever produced; the all-ones value wraps only via the rollover rule.
- Flags are computed from the next count and registered, so they are valid in the same cycle as count_out:
  - rollover_flag = (next == rollover_val), using rollover_val sampled at that edge.
  - zero_flag = (next == 0).
  - wrap_pulse = wrap recorded at that edge. It is never high for two consecutive cycles unless wraps occur on consecutive edges (e.g. rollover_val=1, up, wrap mode).
- Changing rollover_val mid-count takes effect at the next edge. No other correction is applied.

## Timing
- Single-cycle latency: control inputs sampled at edge N appear on count_out and flags after edge N.
- No combinational path from any input to any output.
- Reset is synchronous: asserting rst mid-count has no effect until the next rising edge, then all outputs are 0.
- clear, load and count_enable asserted together: clear wins.
- load and count_enable asserted together: load_val is taken and no step is applied.
- count_down or saturate toggled between edges: the new value applies to the next edge only.

## Test plan
- Reset: rst=1 for 2 edges mid-count at 5 → count_out=0 and all flags 0 after the first edge with rst=1. After rst drops with enable=0 → count_out stays 0 and zero_flag=1.
- Up wrap: NUM_BITS=4, rollover_val=3, saturate=0, enable=1 from 0 → count_out 1,2,3,1,2,3. rollover_flag=1 exactly in the cycles where count=3. wrap_pulse=1 only in the cycles where count just became 1 via wrap.
- Up saturate: rollover_val=5, saturate=1 → 1..5 then holds 5 for ≥3 cycles; rollover_flag stays 1; wrap_pulse stays 0.
- Down wrap: load_val=2 loaded, rollover_val=6, count_down=1, enable=1 → 1,6,5,4. wrap_pulse=1 in the cycle count=6. Then saturate=1 from count=2 → 1,1,1.
- Priority/out-of-range: clear+load+enable in one cycle → 0. load_val=9 with rollover_val=5 → count 9 → up enable gives 1 with wrap_pulse=1. load with enable=1 → exactly load_val.
- rollover_val=0: enable=1 for 4 cycles from count 7 → count holds 7, wrap_pulse=0. Then load_val=2 → count 2.
